rf_wr_arbiter: RTL and testbench

//  Shares the register file's single write port between NUM_REQ writeback sources (ALU, load unit, debug).

---
 rtl/rf_wr_arbiter_pkg.sv | 23 ++
 rtl/rf_wr_arbiter_if.sv | 30 +++
 rtl/rf_wr_arbiter_rr_pick.sv | 34 +++
 rtl/rf_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared constants, FSM state type and round-robin helper for the
// register-file write-port arbiter.
package noobs_rf_pkg;

  localparam int REG_W    = 8;
  localparam int SEL_W    = 2;
  localparam int NUM_REGS = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Distance of requester idx from the round-robin pointer, modulo n.
  function automatic int rr_dist(input int idx, input int ptr, input int n);
    if (idx >= ptr) begin
      return idx - ptr;
    end else begin
      return idx + n - ptr;
    end
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester handshake and register-file write bus of the write-port arbiter.
interface rf_wr_arbiter_if
  import noobs_rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 3
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_lock;
  logic [SEL_W*NUM_REQ-1:0] req_sel;
  logic [REG_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     wr_en;
  logic [SEL_W-1:0]         wr_sel;
  logic [REG_W-1:0]         wr_data;
  logic                     lock_active;
  logic [IDX_W-1:0]         lock_owner;

  modport master (
    output req_valid, req_lock, req_sel, req_data,
    input  req_ready, wr_en, wr_sel, wr_data, lock_active, lock_owner
  );

  modport slave (
    input  req_valid, req_lock, req_sel, req_data,
    output req_ready, wr_en, wr_sel, wr_data, lock_active, lock_owner
  );

endinterface

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
  import noobs_rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Scan distances 0..NUM_REQ-1 from ptr and take the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && req[i] && (rr_dist(i, int'(ptr), NUM_REQ) == k)) begin
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
          gnt_any = 1'b1;
        end else begin
          gnt_any = gnt_any;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port, with a
// bounded lock for back-to-back writes from one source and a registered output.
module rf_wr_arbiter
  import noobs_rf_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int MAX_LOCK = 4,
  parameter int IDX_W    = 3
) (
  input logic            clk,
  input logic            reset,
  rf_wr_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1) + 1;

  arb_state_e         state_r, state_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic [NUM_REQ-1:0] owner_oh_s;
  logic               owner_valid_s;
  logic               owner_lock_s;
  logic               leave_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               fire_s;
  logic [SEL_W-1:0]   sel_mux_s;
  logic [REG_W-1:0]   data_mux_s;
  logic               wr_en_r;
  logic [SEL_W-1:0]   wr_sel_r;
  logic [REG_W-1:0]   wr_data_r;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (int'(idx) + 1 >= NUM_REQ) begin
      return '0;
    end else begin
      return idx + 1'b1;
    end
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s),
    .gnt_any (pick_any_s)
  );

  // Decode the lock owner and its request/lock bits.
  always_comb begin
    owner_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh_s[i] = (IDX_W'(i) == owner_r);
    end
    owner_valid_s = |(owner_oh_s & bus.req_valid);
    owner_lock_s  = |(owner_oh_s & bus.req_lock);
  end

  // Grant selection and next-state logic for the ARB/LOCKED FSM.
  always_comb begin
    ready_s  = '0;
    leave_s  = 1'b0;
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    owner_s  = owner_r;
    cnt_s    = cnt_r;
    if (reset) begin
      ready_s = '0;
    end else begin
      case (state_r)
        ARB: begin
          ready_s = pick_gnt_s;
          if (pick_any_s) begin
            rr_ptr_s = next_ptr(pick_idx_s);
            if ((|(pick_gnt_s & bus.req_lock)) && (MAX_LOCK > 1)) begin
              state_s = LOCKED;
              owner_s = pick_idx_s;
              cnt_s   = CNT_W'(1);
            end else begin
              state_s = ARB;
            end
          end else begin
            rr_ptr_s = rr_ptr_r;
          end
        end
        LOCKED: begin
          ready_s = owner_oh_s & bus.req_valid;
          // cnt_r+1 is the grant count including this one; release when the
          // next count would reach MAX_LOCK.
          if (owner_valid_s) begin
            cnt_s   = cnt_r + 1'b1;
            leave_s = !owner_lock_s || (int'(cnt_r) + 2 >= MAX_LOCK);
          end else begin
            leave_s = !owner_lock_s;
          end
          if (leave_s) begin
            state_s  = ARB;
            rr_ptr_s = next_ptr(owner_r);
            cnt_s    = '0;
            owner_s  = '0;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s  = ARB;
          rr_ptr_s = '0;
          owner_s  = '0;
          cnt_s    = '0;
        end
      endcase
    end
  end

  assign fire_s = |ready_s;

  // AND-OR mux of the granted requester's select and data.
  always_comb begin
    sel_mux_s  = '0;
    data_mux_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_mux_s  = sel_mux_s  | (bus.req_sel[SEL_W*i +: SEL_W]  & {SEL_W{ready_s[i]}});
      data_mux_s = data_mux_s | (bus.req_data[REG_W*i +: REG_W] & {REG_W{ready_s[i]}});
    end
  end

  // State, pointer, lock counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ARB;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      cnt_r     <= '0;
      wr_en_r   <= 1'b0;
      wr_sel_r  <= '0;
      wr_data_r <= '0;
    end else begin
      state_r   <= state_s;
      rr_ptr_r  <= rr_ptr_s;
      owner_r   <= owner_s;
      cnt_r     <= cnt_s;
      wr_en_r   <= fire_s;
      wr_sel_r  <= sel_mux_s;
      wr_data_r <= data_mux_s;
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.wr_en       = wr_en_r;
  assign bus.wr_sel      = wr_sel_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.lock_active = (state_r == LOCKED);
  assign bus.lock_owner  = owner_r;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter (NUM_REQ=3, MAX_LOCK=4).
module tb_rf_wr_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  rf_wr_arbiter_if #(.NUM_REQ(3), .IDX_W(3)) bus ();

  rf_wr_arbiter #(
    .NUM_REQ  (3),
    .MAX_LOCK (4),
    .IDX_W    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] s, input logic [7:0] d);
    bus.req_sel[2*i +: 2]  = s;
    bus.req_data[8*i +: 8] = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_lock  = 3'b000;
    bus.req_sel   = 6'd0;
    bus.req_data  = 24'd0;
    for (int i = 0; i < 3; i++) set_req(i, 2'(i), 8'(8'hD0 + i));

    // Reset held two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_lock_active", 32'(bus.lock_active), 32'd0);
    end
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_wr_sel", 32'(bus.wr_sel), 32'd0);
    chk("rst_lock_owner", 32'(bus.lock_owner), 32'd0);
    reset = 1'b0;
    #1;

    // Round-robin with all three valid, no lock
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 32'(bus.req_ready), 32'd1 << (k % 3));
      if (k == 0) begin
        chk("rr_first_idle", 32'(bus.wr_en), 32'd0);
      end else begin
        chk("rr_wr_en", 32'(bus.wr_en), 32'd1);
        chk("rr_wr_sel", 32'(bus.wr_sel), 32'((k - 1) % 3));
        chk("rr_wr_data", 32'(bus.wr_data), 32'(32'hD0 + (k - 1) % 3));
      end
      step();
    end
    chk("rr_last_wr_en", 32'(bus.wr_en), 32'd1);
    chk("rr_last_wr_data", 32'(bus.wr_data), 32'hD2);
    bus.req_valid = 3'b000;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("idle_wr_en", 32'(bus.wr_en), 32'd0);

    // Voluntary lock: req1 three writes back to back, req0 valid throughout
    bus.req_valid = 3'b011;
    bus.req_lock  = 3'b010;
    set_req(0, 2'd0, 8'h11);
    set_req(1, 2'd2, 8'hA5);
    #1;
    chk("lk_pre_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("lk_g1_ready", 32'(bus.req_ready), 32'd2);
    step();
    chk("lk_active1", 32'(bus.lock_active), 32'd1);
    chk("lk_owner1", 32'(bus.lock_owner), 32'd1);
    chk("lk_wr1_data", 32'(bus.wr_data), 32'hA5);
    chk("lk_wr1_sel", 32'(bus.wr_sel), 32'd2);
    set_req(1, 2'd2, 8'h5A);
    #1;
    chk("lk_g2_ready", 32'(bus.req_ready), 32'd2);
    step();
    chk("lk_wr2_data", 32'(bus.wr_data), 32'h5A);
    set_req(1, 2'd2, 8'h3C);
    bus.req_lock = 3'b000;
    #1;
    chk("lk_g3_ready", 32'(bus.req_ready), 32'd2);
    chk("lk_active3", 32'(bus.lock_active), 32'd1);
    step();
    bus.req_valid = 3'b001;
    #1;
    chk("lk_released", 32'(bus.lock_active), 32'd0);
    chk("lk_rr_ptr", 32'(dut.rr_ptr_r), 32'd2);
    chk("lk_req0_ready", 32'(bus.req_ready), 32'd1);
    chk("lk_wr3_data", 32'(bus.wr_data), 32'h3C);
    step();
    chk("lk_wr_req0", 32'(bus.wr_data), 32'h11);
    bus.req_valid = 3'b000;

    // Forced release: req2 keeps lock asserted, req0 waiting
    bus.req_valid = 3'b101;
    bus.req_lock  = 3'b100;
    set_req(2, 2'd3, 8'hC0);
    #1;
    chk("fr_g1_ready", 32'(bus.req_ready), 32'd4);
    step();
    set_req(2, 2'd3, 8'hC1);
    #1;
    chk("fr_g2_ready", 32'(bus.req_ready), 32'd4);
    chk("fr_active", 32'(bus.lock_active), 32'd1);
    chk("fr_owner", 32'(bus.lock_owner), 32'd2);
    step();
    set_req(2, 2'd3, 8'hC2);
    #1;
    chk("fr_g3_ready", 32'(bus.req_ready), 32'd4);
    step();
    set_req(2, 2'd3, 8'hC3);
    #1;
    chk("fr_release", 32'(bus.lock_active), 32'd0);
    chk("fr_owner_clr", 32'(bus.lock_owner), 32'd0);
    chk("fr_req0_ready", 32'(bus.req_ready), 32'd1);
    chk("fr_wr3_data", 32'(bus.wr_data), 32'hC2);
    chk("fr_wr3_sel", 32'(bus.wr_sel), 32'd3);
    step();
    chk("fr_wr_req0", 32'(bus.wr_data), 32'h11);
    bus.req_valid = 3'b000;
    bus.req_lock  = 3'b000;

    // Idle lock: owner drops valid but keeps lock
    bus.req_valid = 3'b011;
    bus.req_lock  = 3'b010;
    set_req(1, 2'd1, 8'h66);
    #1;
    chk("il_enter_ready", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 3'b001;
    #1;
    chk("il_active", 32'(bus.lock_active), 32'd1);
    chk("il_wr_enter", 32'(bus.wr_data), 32'h66);
    for (int c = 0; c < 3; c++) begin
      chk("il_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("il_wr_en", 32'(bus.wr_en), 32'd0);
      chk("il_hold", 32'(bus.lock_active), 32'd1);
    end
    bus.req_lock = 3'b000;
    #1;
    chk("il_rel_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("il_arb", 32'(bus.lock_active), 32'd0);
    chk("il_req0_ready", 32'(bus.req_ready), 32'd1);
    chk("il_rel_wr_en", 32'(bus.wr_en), 32'd0);
    step();
    chk("il_wr_req0_en", 32'(bus.wr_en), 32'd1);
    chk("il_wr_req0", 32'(bus.wr_data), 32'h11);
    bus.req_valid = 3'b000;

    // Reset mid-lock with a write already registered
    bus.req_valid = 3'b010;
    bus.req_lock  = 3'b010;
    set_req(1, 2'd3, 8'h77);
    #1;
    chk("rm_enter_ready", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 3'b011;
    #1;
    chk("rm_wr_before", 32'(bus.wr_en), 32'd1);
    chk("rm_locked", 32'(bus.lock_active), 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_ready_rst", 32'(bus.req_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rm_wr_dropped", 32'(bus.wr_en), 32'd0);
    chk("rm_arb", 32'(bus.lock_active), 32'd0);
    chk("rm_rr_ptr", 32'(dut.rr_ptr_r), 32'd0);
    chk("rm_req0_first", 32'(bus.req_ready), 32'd1);
    step();
    chk("rm_wr_req0_en", 32'(bus.wr_en), 32'd1);
    chk("rm_wr_req0", 32'(bus.wr_data), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
